// File: rtl/perf_types.sv
// rtl/perf_types.sv - shared types and default sizes for the cache performance monitor
// Contents: monitor FSM state enum, default associativity and counter width.
package perf_types;

    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_CNT_W    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating accumulator used for every monitor counter
// Ports: clk, rst (sync, active-high), clr (zero), inc (add enable),
//        add (amount added when inc=1), q (current value, sticks at all-ones).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] add,
    output logic [W-1:0] q
);

    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, q} + {1'b0, add};
    end

    // Clear beats a same-cycle increment; carry-out means the sum overflowed.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc) begin
            q <= sum[W] ? '1 : sum[W-1:0];
        end
    end

endmodule

// File: rtl/cache_perf_monitor.sv
// rtl/cache_perf_monitor.sv - per-way hit / miss counters with snapshot for a cache
// Ports: clk, rst (sync, active-high), req/resp (request accept / complete),
//        hit (per-way tag match in req cycle), clr (zero live counters),
//        freeze (suppress counting), snap (copy live counters to outputs).
//        Outputs hit_cnt (way i at [i*CNT_W +: CNT_W]), hit_total, miss_cnt,
//        snap_valid (one-cycle pulse after snap), busy (request outstanding),
//        multi_hit_err (sticky, more than one way matched).
// Option PERF_MISS_LAT_EN: adds lat_sum / lat_max snapshot outputs holding the
//        summed and largest miss latency (req cycle to resp cycle inclusive).
module cache_perf_monitor
    import perf_types::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      resp,
    input  logic [NUM_WAYS-1:0]       hit,
    input  logic                      clr,
    input  logic                      freeze,
    input  logic                      snap,
    output logic [NUM_WAYS*CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0]          hit_total,
    output logic [CNT_W-1:0]          miss_cnt,
    output logic                      snap_valid,
    output logic                      busy,
    output logic                      multi_hit_err
`ifdef PERF_MISS_LAT_EN
    ,
    output logic [CNT_W-1:0]          lat_sum,
    output logic [CNT_W-1:0]          lat_max
`endif
);

    localparam logic [NUM_WAYS-1:0] WAY_ONE = NUM_WAYS'(1);
    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req && !resp) state_nxt = WAIT;
            WAIT:    if (resp)         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == WAIT);

    // A request is classified only when it is accepted from IDLE.
    logic                classify;
    logic                any_hit;
    logic                multi;
    logic                count_en;
    logic [NUM_WAYS-1:0] hit_low;

    assign classify = req && (state == IDLE);
    assign any_hit  = |hit;
    // x & -x isolates the lowest set bit; x & (x-1) is non-zero iff two or more bits set.
    assign hit_low  = hit & (~hit + WAY_ONE);
    assign multi    = |(hit & (hit - WAY_ONE));
    assign count_en = classify && !freeze;

    logic [NUM_WAYS*CNT_W-1:0] live_hit;
    logic [CNT_W-1:0]          live_total;
    logic [CNT_W-1:0]          live_miss;

    for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way
        sat_counter #(.W(CNT_W)) u_hit_cnt (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .inc (count_en && hit_low[i]),
            .add (CNT_ONE),
            .q   (live_hit[i*CNT_W +: CNT_W])
        );
    end

    sat_counter #(.W(CNT_W)) u_hit_total (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (count_en && any_hit),
        .add (CNT_ONE),
        .q   (live_total)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (count_en && !any_hit),
        .add (CNT_ONE),
        .q   (live_miss)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            multi_hit_err <= 1'b0;
        end else if (classify && multi) begin
            multi_hit_err <= 1'b1;
        end
    end

`ifdef PERF_MISS_LAT_EN
    // lat_timer holds the cycles elapsed so far, counting the req cycle as 1.
    logic [CNT_W-1:0] lat_timer;
    logic             miss_pend;
    logic             lat_done;
    logic             lat_en;
    logic [CNT_W-1:0] lat_val;
    logic [CNT_W-1:0] live_lat_sum;
    logic [CNT_W-1:0] live_lat_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_timer <= '0;
            miss_pend <= 1'b0;
        end else if (classify && !resp) begin
            lat_timer <= CNT_ONE;
            miss_pend <= !any_hit;
        end else if (busy && (lat_timer != '1)) begin
            lat_timer <= lat_timer + CNT_ONE;
        end
    end

    assign lat_done = (classify && resp && !any_hit) || (busy && resp && miss_pend);
    assign lat_val  = !busy ? CNT_ONE :
                      (lat_timer == '1) ? lat_timer : lat_timer + CNT_ONE;
    assign lat_en   = lat_done && !freeze;

    sat_counter #(.W(CNT_W)) u_lat_sum (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (lat_en),
        .add (lat_val),
        .q   (live_lat_sum)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            live_lat_max <= '0;
        end else if (lat_en && (lat_val > live_lat_max)) begin
            live_lat_max <= lat_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_sum <= '0;
            lat_max <= '0;
        end else if (snap) begin
            lat_sum <= live_lat_sum;
            lat_max <= live_lat_max;
        end
    end
`endif

    // Snapshot takes the registered live values, i.e. before this cycle's
    // increment or clear lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt    <= '0;
            hit_total  <= '0;
            miss_cnt   <= '0;
            snap_valid <= 1'b0;
        end else begin
            snap_valid <= snap;
            if (snap) begin
                hit_cnt   <= live_hit;
                hit_total <= live_total;
                miss_cnt  <= live_miss;
            end
        end
    end

endmodule

// File: tb/tb_cache_perf_monitor.sv
// tb/tb_cache_perf_monitor.sv - self-checking bench for cache_perf_monitor
module tb_cache_perf_monitor;

    localparam int NW   = 4;
    localparam int CW   = 8;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          resp;
    logic [NW-1:0] hit;
    logic          clr;
    logic          freeze;
    logic          snap;
    logic [NW*CW-1:0] hit_cnt;
    logic [CW-1:0] hit_total;
    logic [CW-1:0] miss_cnt;
    logic          snap_valid;
    logic          busy;
    logic          multi_hit_err;
`ifdef PERF_MISS_LAT_EN
    logic [CW-1:0] lat_sum;
    logic [CW-1:0] lat_max;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cache_perf_monitor #(.NUM_WAYS(NW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .resp          (resp),
        .hit           (hit),
        .clr           (clr),
        .freeze        (freeze),
        .snap          (snap),
        .hit_cnt       (hit_cnt),
        .hit_total     (hit_total),
        .miss_cnt      (miss_cnt),
        .snap_valid    (snap_valid),
        .busy          (busy),
        .multi_hit_err (multi_hit_err)
`ifdef PERF_MISS_LAT_EN
        ,
        .lat_sum       (lat_sum),
        .lat_max       (lat_max)
`endif
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: integer counters updated from the rules once per edge.
    int m_live_hit[NW];
    int m_live_total, m_live_miss, m_live_lsum, m_live_lmax;
    int m_snap_hit[NW];
    int m_snap_total, m_snap_miss, m_snap_lsum, m_snap_lmax;
    bit m_sv, m_busy, m_err, m_pend_miss, armed;
    int m_start;
    int cyc = 0;
    bit m_cls, m_ldone;
    int m_lat, m_lw;

    function automatic int sat(input int v);
        return (v > MAXV) ? MAXV : v;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int k = 0; k < NW; k++) begin
                m_live_hit[k] = 0;
                m_snap_hit[k] = 0;
            end
            m_live_total = 0; m_live_miss = 0; m_live_lsum = 0; m_live_lmax = 0;
            m_snap_total = 0; m_snap_miss = 0; m_snap_lsum = 0; m_snap_lmax = 0;
            m_sv = 0; m_busy = 0; m_err = 0; m_pend_miss = 0;
            armed = 1;
        end else begin
            m_cls = req && !m_busy;
            m_sv  = snap;
            if (snap) begin
                for (int k = 0; k < NW; k++) m_snap_hit[k] = m_live_hit[k];
                m_snap_total = m_live_total;
                m_snap_miss  = m_live_miss;
                m_snap_lsum  = m_live_lsum;
                m_snap_lmax  = m_live_lmax;
            end
            m_ldone = 0;
            m_lat   = 0;
            if (m_cls && resp && hit == 0) begin
                m_ldone = 1; m_lat = 1;
            end else if (m_busy && resp && m_pend_miss) begin
                m_ldone = 1; m_lat = cyc - m_start + 1;
            end
            if (clr) begin
                for (int k = 0; k < NW; k++) m_live_hit[k] = 0;
                m_live_total = 0; m_live_miss = 0; m_live_lsum = 0; m_live_lmax = 0;
                m_err = 0;
            end else begin
                if (m_cls && $countones(hit) > 1) m_err = 1;
                if (m_cls && !freeze) begin
                    if (hit == 0) begin
                        m_live_miss = sat(m_live_miss + 1);
                    end else begin
                        m_lw = 0;
                        for (int k = NW - 1; k >= 0; k--) if (hit[k]) m_lw = k;
                        m_live_hit[m_lw] = sat(m_live_hit[m_lw] + 1);
                        m_live_total     = sat(m_live_total + 1);
                    end
                end
                if (m_ldone && !freeze) begin
                    m_live_lsum = sat(m_live_lsum + m_lat);
                    if (m_lat > m_live_lmax) m_live_lmax = sat(m_lat);
                end
            end
            if (!m_busy) begin
                if (req && !resp) begin
                    m_busy = 1; m_start = cyc; m_pend_miss = (hit == 0);
                end
            end else if (resp) begin
                m_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < NW; k++)
                chk($sformatf("cyc_hit_cnt%0d", k), hit_cnt[k*CW +: CW], m_snap_hit[k]);
            chk("cyc_hit_total", hit_total, m_snap_total);
            chk("cyc_miss_cnt", miss_cnt, m_snap_miss);
            chk("cyc_snap_valid", snap_valid, m_sv);
            chk("cyc_busy", busy, m_busy);
            chk("cyc_multi_hit_err", multi_hit_err, m_err);
`ifdef PERF_MISS_LAT_EN
            chk("cyc_lat_sum", lat_sum, m_snap_lsum);
            chk("cyc_lat_max", lat_max, m_snap_lmax);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request whose resp lands lat cycles after (and including) the req cycle.
    task automatic do_req(input logic [NW-1:0] h, input int lat);
        req = 1'b1;
        hit = h;
        if (lat <= 1) begin
            resp = 1'b1;
            step();
            resp = 1'b0;
            req  = 1'b0;
        end else begin
            step();
            req = 1'b0;
            hit = '0;
            chk("busy_in_wait", busy, 1);
            repeat (lat - 2) step();
            resp = 1'b1;
            step();
            resp = 1'b0;
        end
        hit = '0;
    endtask

    task automatic do_snap();
        snap = 1'b1;
        step();
        snap = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; resp = 1'b0; hit = '0;
        clr = 1'b0; freeze = 1'b0; snap = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        chk("rst_hit_total", hit_total, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_snap_valid", snap_valid, 0);
        chk("rst_multi_hit_err", multi_hit_err, 0);

        // Three one-cycle hits on way 1.
        repeat (3) do_req(4'b0010, 1);
        do_snap();
        chk("w1_hit_cnt1", hit_cnt[CW +: CW], 3);
        chk("w1_hit_total", hit_total, 3);
        chk("w1_miss_cnt", miss_cnt, 0);
        chk("w1_snap_valid_hi", snap_valid, 1);
        step();
        chk("w1_snap_valid_lo", snap_valid, 0);

        // Multi-way hit counts on the lowest way and sets the sticky error.
        do_clr();
        do_req(4'b1010, 1);
        do_snap();
        chk("mh_hit_cnt1", hit_cnt[CW +: CW], 1);
        chk("mh_hit_cnt3", hit_cnt[3*CW +: CW], 0);
        chk("mh_err_set", multi_hit_err, 1);
        repeat (5) step();
        chk("mh_err_held", multi_hit_err, 1);
        do_clr();
        chk("mh_err_clr", multi_hit_err, 0);

        // Snap and clear together keep the pre-clear values.
        repeat (5) do_req(4'b0000, 3);
        snap = 1'b1; clr = 1'b1;
        step();
        snap = 1'b0; clr = 1'b0;
        chk("sc_miss_cnt5", miss_cnt, 5);
        do_snap();
        chk("sc_miss_cnt0", miss_cnt, 0);

        // Miss latencies of 5 and 9 cycles.
        do_clr();
        do_req(4'b0000, 5);
        do_req(4'b0000, 9);
        do_snap();
        chk("lat_miss_cnt", miss_cnt, 2);
`ifdef PERF_MISS_LAT_EN
        chk("lat_sum14", lat_sum, 14);
        chk("lat_max9", lat_max, 9);
`endif

        // Requests raised while waiting are ignored.
        do_clr();
        req = 1'b1; hit = 4'b0001;
        step();
        hit = 4'b0010;
        repeat (3) step();
        req = 1'b0; hit = '0; resp = 1'b1;
        step();
        resp = 1'b0;
        do_snap();
        chk("ign_hit_total", hit_total, 1);
        chk("ign_hit_cnt0", hit_cnt[0 +: CW], 1);
        chk("ign_hit_cnt1", hit_cnt[CW +: CW], 0);

        // Snap in an increment cycle sees the value before the increment.
        do_clr();
        req = 1'b1; resp = 1'b1; hit = 4'b0100; snap = 1'b1;
        step();
        req = 1'b0; resp = 1'b0; hit = '0; snap = 1'b0;
        chk("pre_inc_total", hit_total, 0);
        do_snap();
        chk("post_inc_total", hit_total, 1);
        chk("post_inc_cnt2", hit_cnt[2*CW +: CW], 1);

        // Freeze suppresses counting; freeze only at resp drops just the latency.
        do_clr();
        freeze = 1'b1;
        do_req(4'b0001, 1);
        do_req(4'b0000, 4);
        freeze = 1'b0;
        req = 1'b1; hit = '0;
        step();
        req = 1'b0;
        step();
        freeze = 1'b1; resp = 1'b1;
        step();
        freeze = 1'b0; resp = 1'b0;
        do_snap();
        chk("frz_hit_total", hit_total, 0);
        chk("frz_miss_cnt", miss_cnt, 1);
`ifdef PERF_MISS_LAT_EN
        chk("frz_lat_sum", lat_sum, 0);
`endif

        // Reset in the middle of a wait drops the request.
        do_clr();
        req = 1'b1; hit = '0;
        step();
        req = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0; resp = 1'b1;
        step();
        resp = 1'b0;
        chk("rw_busy", busy, 0);
        do_snap();
        chk("rw_miss_cnt", miss_cnt, 0);
`ifdef PERF_MISS_LAT_EN
        chk("rw_lat_sum", lat_sum, 0);
        chk("rw_lat_max", lat_max, 0);
`endif

        // Saturation at all-ones.
        repeat (260) do_req(4'b0001, 1);
        do_snap();
        chk("sat_hit_cnt0", hit_cnt[0 +: CW], 255);
        chk("sat_hit_total", hit_total, 255);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
